// File: rtl/key_debounce.sv
// Raw active-low key pins -> synchronised, debounced key_state plus a press/release event FIFO.
// Optional KEY_RELEASE_EVENTS_EN: when defined, release flips also queue events (default: presses only).
module key_debounce #(
    parameter  int N_KEYS          = 2,
    parameter  int DEBOUNCE_CYCLES = 4,
    parameter  int FIFO_DEPTH      = 4,
    localparam int KIDX_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_state,
    output logic              ev_valid,
    output logic [KIDX_W:0]   ev_data,
    input  logic              ev_ready,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EV_W  = KIDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [N_KEYS-1:0]             meta_q, sync_q;
    logic [N_KEYS-1:0]             stable_q, stable_d;
    logic [N_KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_KEYS-1:0]             key_state_q, key_state_d;
    logic [N_KEYS-1:0]             pending_q, pending_d;
    logic [N_KEYS-1:0]             dir_q, dir_d;
    logic [FIFO_DEPTH-1:0][EV_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]                count_q, count_d;
    logic                          ovf_q, ovf_d;

    logic [N_KEYS-1:0] flip;
    logic [N_KEYS-1:0] ev_flip;
    logic [N_KEYS-1:0] grant_oh;
    logic [KIDX_W-1:0] grant_idx;
    logic [EV_W-1:0]   push_data;
    logic              push, pop, full, drop, wr_en;

    // First synchroniser stage is a plain flop with nothing in front of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= key_n;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flip     = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (sync_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    stable_d[k] = sync_q[k];
                    cnt_d[k]    = '0;
                    flip[k]     = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
        key_state_d = ~stable_d;
    end

    // A flip to stable 0 is a press; only those queue unless release events are enabled.
    always_comb begin
`ifdef KEY_RELEASE_EVENTS_EN
        ev_flip = flip;
`else
        ev_flip = flip & ~sync_q;
`endif
        dir_d = dir_q;
        for (int k = 0; k < N_KEYS; k++) begin
            if (ev_flip[k]) begin
                dir_d[k] = ~sync_q[k];
            end
        end
    end

    always_comb begin
        grant_oh  = pending_q & (~pending_q + N_KEYS'(1));
        grant_idx = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                grant_idx = KIDX_W'(k);
            end
        end
        push_data = {dir_q[grant_idx], grant_idx};
        push      = |pending_q;
        pending_d = (pending_q & ~grant_oh) | ev_flip;
    end

    // A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
    always_comb begin
        ev_valid = (count_q != '0);
        full     = (count_q == FIFO_FULL);
        pop      = ev_valid && ev_ready;
        drop     = push && full && !pop;
        wr_en    = push && !drop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q    <= '1;
            cnt_q       <= '0;
            key_state_q <= '0;
            pending_q   <= '0;
            dir_q       <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_state = key_state_q;
    assign ev_data   = ev_valid ? mem_q[rd_ptr_q] : '0;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus randomised pins checked against a queue-based model.
module tb_key_debounce;
    localparam int N     = 2;
    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int KW    = 1;
    localparam int EW    = KW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  key_n = '1;
    logic          ev_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [N-1:0]  key_state;
    logic          ev_valid;
    logic [EW-1:0] ev_data;
    logic          ovf;

    always #5 clk = ~clk;

    key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_state(key_state),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: debounced level flips after D consecutive differing synced samples.
    logic [N-1:0]  m_stable;
    int            m_run[N];
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_dir;
    logic [EW-1:0] m_q[$];
    logic          m_ovf;
    logic [N-1:0]  hist[$];

    task automatic model_reset();
        m_stable = '1;
        for (int k = 0; k < N; k++) m_run[k] = 0;
        m_pend = '0;
        m_dir  = '0;
        m_q.delete();
        m_ovf = 1'b0;
        hist.delete();
        hist.push_back('1);
        hist.push_back('1);
    endtask

    function automatic logic [EW-1:0] exp_data();
        return (m_q.size() > 0) ? m_q[0] : '0;
    endfunction

    task automatic step();
        logic [N-1:0]  kin, seen;
        logic          rdy, clr, pop, drop;
        int            g;
        logic [KW-1:0] gi;
        kin = key_n;
        rdy = ev_ready;
        clr = ovf_clr;
        @(posedge clk);
        #1;
        seen = hist[1];
        g = -1;
        for (int k = N - 1; k >= 0; k--) if (m_pend[k]) g = k;
        pop  = (m_q.size() > 0) && rdy;
        drop = (g >= 0) && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            gi = g[KW-1:0];
            if (!drop) m_q.push_back({m_dir[g], gi});
            m_pend[g] = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (seen[k] != m_stable[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_stable[k] = seen[k];
                    m_run[k] = 0;
`ifdef KEY_RELEASE_EVENTS_EN
                    m_pend[k] = 1'b1;
                    m_dir[k]  = ~seen[k];
`else
                    if (seen[k] == 1'b0) begin
                        m_pend[k] = 1'b1;
                        m_dir[k]  = 1'b1;
                    end
`endif
                end
            end else begin
                m_run[k] = 0;
            end
        end
        hist.push_front(kin);
        while (hist.size() > 2) void'(hist.pop_back());
    endtask

    task automatic test_reset();
        model_reset();
        key_n = '1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({key_state, ev_valid, ev_data, ovf} !== '0)
            $display("FAIL reset_during: got ks=%b v=%b d=%b ovf=%b want all 0", key_state, ev_valid, ev_data, ovf);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_total++;
            if ({key_state, ev_valid, ev_data, ovf} !== '0)
                $display("FAIL reset_idle c%0d: got ks=%b v=%b d=%b ovf=%b want all 0", i, key_state, ev_valid, ev_data, ovf);
            else n_pass++;
        end
    endtask

    task automatic test_press();
        key_n[0] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_total++;
            if (key_state[0] !== (i >= 6))
                $display("FAIL press_latency c%0d: got %b want %b", i, key_state[0], (i >= 6));
            else n_pass++;
            if (i == 6) begin
                n_total++;
                if (ev_valid !== 1'b0) $display("FAIL press_early_valid: got %b want 0", ev_valid);
                else n_pass++;
            end
        end
        n_total++;
        if (ev_valid !== 1'b1 || ev_data !== 2'b10)
            $display("FAIL press_event: got v=%b d=%b want v=1 d=10", ev_valid, ev_data);
        else n_pass++;
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_total++;
        if (ev_valid !== 1'b0) $display("FAIL press_pop: got v=%b want 0", ev_valid);
        else n_pass++;
    endtask

    task automatic test_glitch();
        key_n[1] = 1'b0;
        repeat (3) step();
        key_n[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_total++;
            if (key_state !== 2'b01 || ev_valid !== 1'b0)
                $display("FAIL glitch c%0d: got ks=%b v=%b want ks=01 v=0", i, key_state, ev_valid);
            else n_pass++;
        end
    endtask

    task automatic test_release();
        key_n[0] = 1'b1;
        repeat (7) step();
        n_total++;
        if (key_state !== 2'b00) $display("FAIL release_state: got %b want 00", key_state);
        else n_pass++;
`ifdef KEY_RELEASE_EVENTS_EN
        n_total++;
        if (ev_valid !== 1'b1 || ev_data !== 2'b00)
            $display("FAIL release_event: got v=%b d=%b want v=1 d=00", ev_valid, ev_data);
        else n_pass++;
`else
        n_total++;
        if (ev_valid !== 1'b0) $display("FAIL release_no_event: got v=%b want 0", ev_valid);
        else n_pass++;
`endif
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_total++;
        if (ev_valid !== 1'b0 || ovf !== 1'b0)
            $display("FAIL release_drain: got v=%b ovf=%b want 0 0", ev_valid, ovf);
        else n_pass++;
    endtask

    task automatic test_both();
        key_n = 2'b00;
        repeat (8) step();
        n_total++;
        if (ev_valid !== 1'b1 || ev_data !== 2'b10)
            $display("FAIL both_first: got v=%b d=%b want v=1 d=10", ev_valid, ev_data);
        else n_pass++;
        ev_ready = 1'b1;
        step();
        n_total++;
        if (ev_valid !== 1'b1 || ev_data !== 2'b11)
            $display("FAIL both_second: got v=%b d=%b want v=1 d=11", ev_valid, ev_data);
        else n_pass++;
        step();
        ev_ready = 1'b0;
        n_total++;
        if (ev_valid !== 1'b0) $display("FAIL both_empty: got v=%b want 0", ev_valid);
        else n_pass++;
        key_n = '1;
        repeat (10) step();
        ev_ready = 1'b1;
        repeat (3) step();
        ev_ready = 1'b0;
        n_total++;
        if (ev_valid !== 1'b0 || key_state !== 2'b00)
            $display("FAIL both_release: got v=%b ks=%b want 0 00", ev_valid, key_state);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic seen;
        ev_ready = 1'b0;
        key_n = 2'b00; repeat (10) step();
        key_n = 2'b11; repeat (10) step();
        key_n = 2'b00; repeat (10) step();
        key_n = 2'b11; repeat (10) step();
        key_n = 2'b10; repeat (10) step();
        n_total++;
        if (ovf !== 1'b1 || ev_valid !== 1'b1 || ev_data !== 2'b10)
            $display("FAIL ovf_set: got ovf=%b v=%b d=%b want 1 1 10", ovf, ev_valid, ev_data);
        else n_pass++;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_total++;
        if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf);
        else n_pass++;
        key_n = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (m_pend != '0) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL ovf_wait_push: got no pending flip want one within 20 cycles");
        else n_pass++;
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_total++;
        if (ovf !== 1'b0 || ev_valid !== 1'b1 || ev_data !== exp_data())
            $display("FAIL full_push_pop: got ovf=%b v=%b d=%b want 0 1 %b", ovf, ev_valid, ev_data, exp_data());
        else n_pass++;
        ev_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++;
            if (ev_valid !== 1'b1 || ev_data !== exp_data())
                $display("FAIL full_drain e%0d: got v=%b d=%b want 1 %b", i, ev_valid, ev_data, exp_data());
            else n_pass++;
            step();
        end
        ev_ready = 1'b0;
        n_total++;
        if (ev_valid !== 1'b0) $display("FAIL full_count: got v=%b want 0 after %0d pops", ev_valid, DEPTH);
        else n_pass++;
        key_n = '1;
        repeat (10) step();
        ev_ready = 1'b1;
        repeat (4) step();
        ev_ready = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                key_n[$urandom_range(N - 1, 0)] ^= 1'b1;
                hold = $urandom_range(12, 1);
            end else begin
                hold--;
            end
            ev_ready = (c < 300) ? ($urandom % 5 == 0) : ($urandom % 2 == 0);
            ovf_clr  = ($urandom % 25 == 0);
            step();
            n_total++;
            if (key_state !== ~m_stable)
                $display("FAIL rnd_state c%0d: got %b want %b", c, key_state, ~m_stable);
            else n_pass++;
            n_total++;
            if (ev_valid !== (m_q.size() > 0))
                $display("FAIL rnd_valid c%0d: got %b want %b", c, ev_valid, (m_q.size() > 0));
            else n_pass++;
            n_total++;
            if (ev_data !== exp_data())
                $display("FAIL rnd_data c%0d: got %b want %b", c, ev_data, exp_data());
            else n_pass++;
            n_total++;
            if (ovf !== m_ovf)
                $display("FAIL rnd_ovf c%0d: got %b want %b", c, ovf, m_ovf);
            else n_pass++;
        end
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic test_reset_mid();
        key_n = 2'b00;
        ev_ready = 1'b0;
        repeat (9) step();
        #2 rst_n = 1'b0;
        key_n = '1;
        #1;
        model_reset();
        n_total++;
        if ({key_state, ev_valid, ev_data, ovf} !== '0)
            $display("FAIL reset_mid: got ks=%b v=%b d=%b ovf=%b want all 0", key_state, ev_valid, ev_data, ovf);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if (ev_valid !== 1'b0 || key_state !== 2'b00)
                $display("FAIL reset_mid_after c%0d: got v=%b ks=%b want 0 00", i, ev_valid, key_state);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_both();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
